instr_stream_encoder: RTL
=========================

Name: instr_stream_encoder

Overview:
- Encodes a stream of symbolic instructions into 32-bit instruction words and writes them sequentially into instruction memory. It is the encoding direction of the control-unit decode tables.
- Fields per instruction: op class, cmd, imm flag, rd, rn, rm/imm16.
- Sits between the host/debug loader path and the instruction memory write port. Used for program load before the core is released from reset.
- Rejects illegal op/cmd combinations and counts them. It guards against instruction-memory overflow.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 1024, number of writable words; addresses BASE_ADDR..BASE_ADDR+DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a load session; ignored unless state is IDLE.
- in_valid  in  1  instruction tuple valid.
- in_ready  out  1  block accepts the tuple this cycle.
- in_op  in  2  class: PROCESSING 00, MEMORY 01, FLOW 10.
- in_cmd  in  5  command code, right-aligned: MEMORY uses [1:0], FLOW uses [0].
- in_imm  in  1  WITH_IMM=1 / WITHOUT_IMM=0.
- in_rd  in  4  destination register.
- in_rn  in  4  first source register.
- in_rm  in  4  second source register, used when in_imm=0.
- in_imm16  in  16  immediate, used when in_imm=1.
- in_last  in  1  tuple is the final instruction of the session.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  state is LOAD or DONE.
- load_done  out  1  one-cycle pulse at session end.
- overflow  out  1  sticky: a tuple arrived with the memory full.
- word_count  out  ADDR_W+1  words written in the current session.
- err_count  out  8  illegal tuples dropped this session; saturates at 255.

Behaviour:
- Word format:
  - [31:30] op; [29] imm; [28:24] cmd field; [23:20] rd; [19:16] rn.
  - in_imm=1: [15:0]=imm16.
  - in_imm=0: [15:12]=rm, [11:0]=0.
  - MEMORY: cmd field = {3'b000, cmd[1:0]}. FLOW: cmd field = {4'b0000, cmd[0]}.
- Legality:
  - PROCESSING with cmd <= 5'b01100 (NOP..COS).
  - MEMORY with cmd[4:2]=0.
  - FLOW with cmd[4:1]=0.
  - Anything else, including op=11, is illegal.
- Reset: state IDLE; all outputs 0; imem_addr=BASE_ADDR; counters and overflow cleared.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD next cycle; word_count, err_count and overflow cleared; write pointer set to BASE_ADDR.
- LOAD:
  - in_ready=1 unless word_count==DEPTH.
  - Accepted legal tuple at cycle N: imem_we=1 at cycle N+1 with the encoded word at the current pointer. Pointer and word_count increment after the write.
  - Throughput is 1 word/cycle, back-to-back.
  - Accepted illegal tuple: no write; err_count++ (saturating).
  - Accepted tuple with in_last=1, legal or illegal: after its write slot (N+1) -> DONE.
- Full condition:
  - With word_count==DEPTH, in_ready=0.
  - If in_valid=1 in that state: set overflow, drop the tuple, -> DONE.
- DONE: load_done=1 for exactly one cycle, then IDLE.
- start in LOAD or DONE is ignored.
- imem_addr holds its last value when imem_we=0.
- No address wrap-around: the pointer never exceeds BASE_ADDR+DEPTH-1.
- rst_n low at any time, including mid-write: immediate return to reset values; a pending write is discarded.

Decomposition:
- Shared package (alongside the cu definitions):
  - field position constants: OP_MSB/LSB, IMM_BIT, CMD_MSB/LSB, RD/RN/RM/IMM16 positions;
  - the PROCESSING/MEMORY/FLOW op and cmd codes (reused, not redefined);
  - a packed struct instr_tuple_t for the input fields;
  - a function cmd_is_legal(op, cmd).
- One combinational sub-module: instr_field_packer (tuple -> {legal, word}). The top-level holds the FSM, pointer, counters and write-stage register.

Test Plan:
- start; ADD imm: op=00 cmd=00100 imm=1 rd=1 rn=2 imm16=0x0005, last=1 -> next cycle imem_we=1, addr=0, data=0x24120005; then load_done pulse; word_count=1.
- STR reg: op=01 cmd=01 imm=0 rd=3 rn=4 rm=5, then BL: op=10 cmd=1 imm=1 imm16=0x0100, last=1, back-to-back -> writes 0x41345000 @0 and 0xA1000100 @1 on consecutive cycles.
- Illegal op=11, then PROCESSING cmd=01101, then legal MOV last=1 -> single write at addr 0; err_count=2.
- DEPTH=4, five legal tuples without last -> four writes at 0..3; in_ready=0 on the fifth; overflow=1; load_done pulse; fifth never written.
- rst_n asserted the cycle after an accepted tuple -> imem_we stays 0; all outputs 0; state IDLE; a new start reloads from BASE_ADDR.
- start pulsed during LOAD -> counters and pointer unaffected; session completes normally.

Source files
------------

// File: rtl/instr_stream_encoder_pkg.sv
// Shared definitions for the instruction stream encoder: field positions,
// op/cmd codes, the input tuple type and the op/cmd legality check.
package instr_stream_encoder_pkg;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 30;
  localparam int IMM_BIT   = 29;
  localparam int CMD_MSB   = 28;
  localparam int CMD_LSB   = 24;
  localparam int RD_MSB    = 23;
  localparam int RD_LSB    = 20;
  localparam int RN_MSB    = 19;
  localparam int RN_LSB    = 16;
  localparam int RM_MSB    = 15;
  localparam int RM_LSB    = 12;
  localparam int IMM16_MSB = 15;
  localparam int IMM16_LSB = 0;

  localparam logic [1:0] OP_PROCESSING = 2'b00;
  localparam logic [1:0] OP_MEMORY     = 2'b01;
  localparam logic [1:0] OP_FLOW       = 2'b10;

  localparam logic [4:0] CMD_NOP = 5'b00000;
  localparam logic [4:0] CMD_MOV = 5'b00010;
  localparam logic [4:0] CMD_ADD = 5'b00100;
  localparam logic [4:0] CMD_COS = 5'b01100;
  localparam logic [4:0] CMD_LDR = 5'b00000;
  localparam logic [4:0] CMD_STR = 5'b00001;
  localparam logic [4:0] CMD_B   = 5'b00000;
  localparam logic [4:0] CMD_BL  = 5'b00001;

  localparam logic       WITH_IMM    = 1'b1;
  localparam logic       WITHOUT_IMM = 1'b0;

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  cmd;
    logic        imm;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [15:0] imm16;
  } instr_tuple_t;

  function automatic logic cmd_is_legal(input logic [1:0] op, input logic [4:0] cmd);
    logic legal;
    case (op)
      OP_PROCESSING: legal = (cmd <= CMD_COS);
      OP_MEMORY:     legal = (cmd[4:2] == 3'b000);
      OP_FLOW:       legal = (cmd[4:1] == 4'b0000);
      default:       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_stream_encoder_packer.sv
// Combinational tuple-to-word packer; flags tuples whose op/cmd pair is illegal.
module instr_field_packer
  import instr_stream_encoder_pkg::*;
(
  input  instr_tuple_t tuple,
  output logic         legal,
  output logic [31:0]  word
);

  logic [4:0] cmd_field;

  // Narrow the cmd field for classes that only use its low bits, then pack.
  always_comb begin
    legal     = cmd_is_legal(tuple.op, tuple.cmd);
    cmd_field = tuple.cmd;
    word      = 32'h0000_0000;
    case (tuple.op)
      OP_MEMORY: cmd_field = {3'b000, tuple.cmd[1:0]};
      OP_FLOW:   cmd_field = {4'b0000, tuple.cmd[0]};
      default:   cmd_field = tuple.cmd;
    endcase
    word[OP_MSB:OP_LSB]   = tuple.op;
    word[IMM_BIT]         = tuple.imm;
    word[CMD_MSB:CMD_LSB] = cmd_field;
    word[RD_MSB:RD_LSB]   = tuple.rd;
    word[RN_MSB:RN_LSB]   = tuple.rn;
    if (tuple.imm == WITH_IMM) begin
      word[IMM16_MSB:IMM16_LSB] = tuple.imm16;
    end else begin
      word[RM_MSB:RM_LSB] = tuple.rm;
    end
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Loads an encoded instruction stream into instruction memory: session FSM,
// saturating write pointer, word/error counters and a registered write stage.
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [4:0]        in_cmd,
  input  logic              in_imm,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [15:0]       in_imm16,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);

  // ST_LAST is the write slot of the final tuple, before the done pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_LAST = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              overflow_q, overflow_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  instr_tuple_t tuple_s;
  logic         legal_s;
  logic [31:0]  word_s;
  logic         full_s;

  assign tuple_s = '{op: in_op, cmd: in_cmd, imm: in_imm, rd: in_rd,
                     rn: in_rn, rm: in_rm, imm16: in_imm16};

  instr_field_packer u_packer (
    .tuple (tuple_s),
    .legal (legal_s),
    .word  (word_s)
  );

  assign full_s = (word_count_q == DEPTH_W);

  // Next-state, counters and write-stage computation.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    overflow_d   = overflow_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_LOAD;
          ptr_d        = BASE_W;
          word_count_d = '0;
          err_count_d  = 8'd0;
          overflow_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (full_s) begin
          if (in_valid) begin
            overflow_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (in_valid) begin
          if (legal_s) begin
            we_d         = 1'b1;
            addr_d       = ptr_q;
            wdata_d      = word_s;
            word_count_d = word_count_q + (ADDR_W+1)'(1);
            // Pointer stops at the last word so it never leaves the window.
            if (word_count_q == DEPTH_W - (ADDR_W+1)'(1)) begin
              ptr_d = ptr_q;
            end else begin
              ptr_d = ptr_q + ADDR_W'(1);
            end
          end else if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end else begin
            err_count_d = err_count_q;
          end
          if (in_last) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LAST: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and write-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= BASE_W;
      word_count_q <= '0;
      err_count_q  <= 8'd0;
      overflow_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= BASE_W;
      wdata_q      <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
      overflow_q   <= overflow_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD) && !full_s;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q != ST_IDLE);
  assign load_done  = (state_q == ST_DONE);
  assign overflow   = overflow_q;
  assign word_count = word_count_q;
  assign err_count  = err_count_q;

endmodule
